// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared frame layout, status bit positions and FSM encoding for the SPI frame dispatcher.
package spi_frame_pkg;
    localparam int FRAME_W  = 512;
    localparam int HDR_BITS = 32;
    localparam int WORD_W   = 16;
    localparam int CTL_EN = 0;
    localparam int CTL_RD = 1;
    localparam int CTL_WR = 2;
    localparam int HB_CTRL   = 0;
    localparam int HB_START  = 1;
    localparam int HB_COUNT  = 2;
    localparam int HB_STATUS = 3;
    localparam int ST_OK    = 0;
    localparam int ST_CLAMP = 1;
    localparam int ST_OVR   = 2;
    localparam int ST_SEQ   = 4;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WRITE,
        S_READ,
        S_READ_TAIL,
        S_DONE
    } state_t;
endpackage

// File: rtl/spi_frame_assembler.sv
// spi_frame_assembler: packs header fields, status and response words into a response frame.
module spi_frame_assembler
    import spi_frame_pkg::*;
#(
    parameter int MAX_WORDS = 30
) (
    input  logic [7:0]         ctrl,
    input  logic [7:0]         start,
    input  logic [7:0]         count,
    input  logic [7:0]         status,
    input  word_t              words [MAX_WORDS],
    output logic [FRAME_W-1:0] frame
);
    always_comb begin
        frame = '0;
        frame[8*HB_CTRL +: 8]   = ctrl;
        frame[8*HB_START +: 8]  = start;
        frame[8*HB_COUNT +: 8]  = count;
        frame[8*HB_STATUS +: 8] = status;
        for (int i = 0; i < MAX_WORDS; i++) frame[HDR_BITS + WORD_W*i +: WORD_W] = words[i];
    end
endmodule

// File: rtl/spi_frame_dispatcher.sv
// spi_frame_dispatcher: decodes a received SPI frame, runs its write/read burst on the
// local register bank and builds the response frame for the next transaction.
module spi_frame_dispatcher
    import spi_frame_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] rx_frame,
    input  logic               rx_strobe,
    output logic [FRAME_W-1:0] tx_frame,
    output logic               tx_valid,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  reg_addr,
    output logic [WORD_W-1:0]  reg_wdata,
    output logic               reg_we,
    output logic               reg_re,
    input  logic [WORD_W-1:0]  reg_rdata
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    state_t state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d, tx_frame_q, tx_frame_d, asm_frame;
    logic [CW-1:0] neff_q, neff_d, cnt_q, cnt_d, cap_q, cap_d, dec_neff;
    logic clamp_q, clamp_d, re_dly_q, re_dly_d, ovr_q, ovr_d, dec_clamp, unused_rsvd;
    logic [3:0] seq_q, seq_d;
    logic tx_valid_q, tx_valid_d, busy_q, busy_d, done_q, done_d, we_q, we_d, re_q, re_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base;
    word_t wdata_q, wdata_d;
    word_t resp_q [MAX_WORDS];
    word_t resp_d [MAX_WORDS];
    word_t pay [MAX_WORDS];
    logic [7:0] ctrl, start, n, status;
    assign ctrl        = frame_q[8*HB_CTRL +: 8];
    assign start       = frame_q[8*HB_START +: 8];
    assign n           = frame_q[8*HB_COUNT +: 8];
    assign unused_rsvd = ^frame_q[8*HB_STATUS +: 8];
    assign base        = ADDR_W'(start);
    assign dec_clamp   = n > 8'(MAX_WORDS);
    assign dec_neff    = dec_clamp ? CW'(MAX_WORDS) : CW'(n);
    // A strobe arriving during DONE is reported with the frame that is finishing.
    assign status = {seq_q, 1'b0, ovr_q | rx_strobe, clamp_q, ctrl[CTL_EN] & (neff_q != '0)};
    always_comb begin
        for (int i = 0; i < MAX_WORDS; i++) pay[i] = frame_q[HDR_BITS + WORD_W*i +: WORD_W];
    end
    spi_frame_assembler #(.MAX_WORDS(MAX_WORDS)) u_asm (
        .ctrl   (ctrl),
        .start  (start),
        .count  (8'(neff_q)),
        .status (status),
        .words  (resp_q),
        .frame  (asm_frame)
    );
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        neff_d     = neff_q;
        clamp_d    = clamp_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        re_dly_d   = re_q;
        ovr_d      = ovr_q;
        seq_d      = seq_q;
        resp_d     = resp_q;
        tx_frame_d = tx_frame_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        // Read data lands two edges after the strobe was issued; capture in issue order.
        if (re_dly_q) begin
            resp_d[cap_q] = reg_rdata;
            cap_d         = cap_q + 1'b1;
        end
        if (rx_strobe && state_q != S_IDLE) ovr_d = 1'b1;
        case (state_q)
            S_IDLE: if (rx_strobe) begin
                frame_d    = rx_frame;
                busy_d     = 1'b1;
                tx_valid_d = 1'b0;
                cap_d      = '0;
                resp_d     = '{default: '0};
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                neff_d  = dec_neff;
                clamp_d = dec_clamp;
                addr_d  = base;
                cnt_d   = CW'(1);
                if (!ctrl[CTL_EN] || dec_neff == '0 || !(ctrl[CTL_RD] || ctrl[CTL_WR])) state_d = S_DONE;
                else if (ctrl[CTL_WR]) begin
                    we_d    = 1'b1;
                    wdata_d = pay[0];
                    state_d = S_WRITE;
                end else begin
                    re_d    = 1'b1;
                    state_d = S_READ;
                end
            end
            S_WRITE: if (cnt_q != neff_q) begin
                we_d    = 1'b1;
                addr_d  = base + ADDR_W'(cnt_q);
                wdata_d = pay[cnt_q];
                cnt_d   = cnt_q + 1'b1;
            end else if (ctrl[CTL_RD]) begin
                re_d    = 1'b1;
                addr_d  = base;
                cnt_d   = CW'(1);
                state_d = S_READ;
            end else state_d = S_DONE;
            S_READ: if (cnt_q != neff_q) begin
                re_d   = 1'b1;
                addr_d = base + ADDR_W'(cnt_q);
                cnt_d  = cnt_q + 1'b1;
            end else state_d = S_READ_TAIL;
            S_READ_TAIL: state_d = S_DONE;
            S_DONE: begin
                tx_frame_d = asm_frame;
                tx_valid_d = 1'b1;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                ovr_d      = 1'b0;
                seq_d      = seq_q + 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            neff_q     <= '0;
            clamp_q    <= 1'b0;
            cnt_q      <= '0;
            cap_q      <= '0;
            re_dly_q   <= 1'b0;
            ovr_q      <= 1'b0;
            seq_q      <= '0;
            resp_q     <= '{default: '0};
            tx_frame_q <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            neff_q     <= neff_d;
            clamp_q    <= clamp_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            re_dly_q   <= re_dly_d;
            ovr_q      <= ovr_d;
            seq_q      <= seq_d;
            resp_q     <= resp_d;
            tx_frame_q <= tx_frame_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
        end
    end
    assign tx_frame  = tx_frame_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
endmodule
